sign_accum: RTL

- Downstream consumer of the sign-window controller's `sign_reset` output.
- While `sign_reset` is low (window open), accumulates a stream of signed samples with saturation.
- When `sign_reset` returns high (window closed), latches the accumulated sum and its sign classification, then presents them on a valid/ready result port.
- Sits between the sign-window controller and the result collector / scoreboard.

---
 rtl/sign_accum.sv | 77 +++++++
 1 files changed

// File: rtl/sign_accum.sv
// sign_accum: saturating signed accumulator over a sign_reset window, result on a valid/ready port
module sign_accum #(
    parameter int DW = 8,
    parameter int AW = 16,
    parameter int TH = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sign_reset,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] din,
    input  logic                 res_ready,
    output logic                 res_valid,
    output logic signed [AW-1:0] acc_out,
    output logic [1:0]           sign_out,
    output logic [15:0]          sample_cnt,
    output logic                 sat_flag,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
    localparam logic signed [AW-1:0] THS  = AW'(TH);
    localparam logic signed [AW-1:0] MAXV = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {1'b1, {(AW-1){1'b0}}};
    state_t state;
    logic signed [AW-1:0] acc, nxt;
    logic signed [AW:0] sum;
    logic [15:0] cnt;
    logic sat, ovf;
    logic [1:0] sgn;
    // one guard bit: overflow shows as disagreement between the top two sum bits
    always_comb begin
        sum = {acc[AW-1], acc} + {{(AW+1-DW){din[DW-1]}}, din};
        ovf = sum[AW] ^ sum[AW-1];
        nxt = ovf ? (sum[AW] ? MINV : MAXV) : sum[AW-1:0];
        sgn = acc > THS ? 2'b01 : acc < -THS ? 2'b11 : 2'b00;
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
            res_valid  <= 1'b0;
            acc_out    <= '0;
            sign_out   <= 2'b00;
            sample_cnt <= '0;
            sat_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!sign_reset) begin
                    state <= ACCUM;
                    acc   <= '0;
                    cnt   <= '0;
                    sat   <= 1'b0;
                end
                ACCUM: if (sign_reset) begin
                    state      <= REPORT;
                    acc_out    <= acc;
                    sign_out   <= sgn;
                    sample_cnt <= cnt;
                    sat_flag   <= sat;
                    res_valid  <= 1'b1;
                end else if (din_valid) begin
                    acc <= nxt;
                    cnt <= cnt + 16'(cnt != 16'hFFFF);
                    sat <= sat | ovf;
                end
                REPORT: if (res_ready) begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
